// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Small DMA helper that sits beside the CPU datapath. On a one-cycle start
// request it copies `length` words from `src_addr` to `dst_addr` through the
// data memory port. Each word takes one read cycle and one write cycle. It also
// keeps a running modulo-2^DATABUS_SIZE checksum of every word it moves.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      copy request, only sampled while idle
//   src_addr   first source word address
//   dst_addr   first destination word address
//   length     number of words to copy (0 is legal)
//   busy       high from start acceptance through the done cycle
//   done       one-cycle completion pulse
//   checksum   sum of the copied words, held until the next accepted start
//   mem_read   registered read strobe to data memory
//   mem_write  registered write strobe to data memory (commits on posedge)
//   address    registered memory address
//   write_data registered memory write data
//   read_data  combinational read data returned by memory
// -----------------------------------------------------------------------------
module mem_copy_engine #(
   parameter int ADDR_BUS_WIDTH = 13,
   parameter int DATABUS_SIZE   = 24
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [ADDR_BUS_WIDTH-1:0] src_addr,
   input  logic [ADDR_BUS_WIDTH-1:0] dst_addr,
   input  logic [ADDR_BUS_WIDTH-1:0] length,
   output logic                      busy,
   output logic                      done,
   output logic [DATABUS_SIZE-1:0]   checksum,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [ADDR_BUS_WIDTH-1:0] address,
   output logic [DATABUS_SIZE-1:0]   write_data,
   input  logic [DATABUS_SIZE-1:0]   read_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_BUS_WIDTH-1:0] ONE = {{(ADDR_BUS_WIDTH-1){1'b0}}, 1'b1};

   state_t                    state_q,      state_d;
   logic                      busy_q,       busy_d;
   logic                      done_q,       done_d;
   logic                      mem_read_q,   mem_read_d;
   logic                      mem_write_q,  mem_write_d;
   logic [ADDR_BUS_WIDTH-1:0] address_q,    address_d;
   logic [DATABUS_SIZE-1:0]   write_data_q, write_data_d;
   logic [DATABUS_SIZE-1:0]   checksum_q,   checksum_d;
   logic [ADDR_BUS_WIDTH-1:0] idx_q,        idx_d;
   logic [ADDR_BUS_WIDTH-1:0] src_q,        src_d;
   logic [ADDR_BUS_WIDTH-1:0] dst_q,        dst_d;
   logic [ADDR_BUS_WIDTH-1:0] len_q,        len_d;

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         address_q    <= '0;
         write_data_q <= '0;
         checksum_q   <= '0;
         idx_q        <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         checksum_q   <= checksum_d;
         idx_q        <= idx_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         len_q        <= len_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      address_d    = address_q;
      write_data_d = write_data_q;
      checksum_d   = checksum_q;
      idx_d        = idx_q;
      src_d        = src_q;
      dst_d        = dst_q;
      len_d        = len_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               checksum_d = '0;
               busy_d     = 1'b1;
               if (length != '0) begin
                  src_d      = src_addr;
                  dst_d      = dst_addr;
                  len_d      = length;
                  idx_d      = '0;
                  mem_read_d = 1'b1;
                  address_d  = src_addr;
                  state_d    = READ;
               end else begin
                  // Zero-length copy: no memory traffic, just the done pulse.
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end

         READ: begin
            // read_data is valid now for address_q = src+idx. The write data
            // register doubles as the captured data word.
            checksum_d   = checksum_q + read_data;
            write_data_d = read_data;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b1;
            address_d    = dst_q + idx_q;
            state_d      = WRITE;
         end

         WRITE: begin
            // Memory commits the word on the edge that leaves this state.
            mem_write_d = 1'b0;
            if (idx_q == len_q - ONE) begin
               address_d = '0;
               done_d    = 1'b1;
               state_d   = DONE;
            end else begin
               idx_d      = idx_q + ONE;
               mem_read_d = 1'b1;
               address_d  = src_q + idx_q + ONE;
               state_d    = READ;
            end
         end

         DONE: begin
            // start is deliberately not looked at here.
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign checksum   = checksum_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign address    = address_q;
   assign write_data = write_data_q;

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator for the data memory port: drives mem_read, mem_write, address and write_data, and captures read_data.
- Copies a block of `length` 24-bit words from `src_addr` to `dst_addr` through that port.
- Accumulates a modulo-2^24 checksum of every word it copies.
- Sits beside the CPU datapath as a small DMA helper, started by a one-cycle request and reporting completion with a done pulse.

Parameters:
- ADDR_BUS_WIDTH, 13, memory address width (8K words).
- DATABUS_SIZE, 24, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  copy request, sampled only in IDLE.
- src_addr  input  ADDR_BUS_WIDTH  first source word address.
- dst_addr  input  ADDR_BUS_WIDTH  first destination word address.
- length  input  ADDR_BUS_WIDTH  number of words to copy; 0 is legal.
- busy  output  1  high from start acceptance through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- checksum  output  DATABUS_SIZE  modulo-2^24 sum of the words copied.
- mem_read  output  1  read strobe to data memory.
- mem_write  output  1  write strobe to data memory (memory commits on posedge).
- address  output  ADDR_BUS_WIDTH  memory address.
- write_data  output  DATABUS_SIZE  memory write data.
- read_data  input  DATABUS_SIZE  combinational read data from memory.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, port rst_n.
- Reset: state=IDLE. busy, done, mem_read, mem_write, address, write_data, checksum, index and latched registers all go to 0 immediately.
- Reset mid-copy: abort with no further strobes. Words already written stay in memory.
- All memory-side outputs are registered. mem_read and mem_write are never high together.
- FSM states and transitions:
  - IDLE, start=1, length!=0: latch src/dst/len, idx=0, checksum=0, mem_read=1, address=src, busy=1 -> READ.
  - IDLE, start=1, length=0: checksum=0, busy=1 -> DONE.
  - IDLE, start=0: hold. checksum keeps its last value.
  - READ (edge): data_reg=read_data, checksum+=read_data, mem_read=0, mem_write=1, address=dst+idx, write_data=read_data -> WRITE.
  - WRITE (edge): memory commits the word. If idx==len-1: mem_write=0, address=0 -> DONE. Else idx+=1, mem_write=0, mem_read=1, address=src+idx -> READ.
  - DONE: done=1 for exactly this one cycle, busy=1. Next edge: busy=0, done=0 -> IDLE.
- start is ignored outside IDLE. start asserted in the DONE cycle is also ignored; it is accepted only once back in IDLE.
- Latency: start accepted at edge 0 gives the last write at edge 2N and done high in cycle 2N..2N+1. Throughput is 2 cycles per word.
- Address arithmetic is modulo 2^ADDR_BUS_WIDTH: src+idx and dst+idx wrap 8191 -> 0.
- Overlap: copy is strictly ascending and word-by-word. When dst lies in (src, src+len), later reads return already-overwritten words. The engine makes no correction.
- Checksum add is truncated to DATABUS_SIZE bits. Its value is held after done until the next accepted start.
- A length of 8191 is the maximum transfer.

Test Plan:
- Basic copy: mem[16]=20, mem[17]=22, mem[18]=5; start src=16 dst=32 len=3 -> mem[32..34]=20,22,5. done pulses in cycle 6 after acceptance. checksum=47. busy falls the cycle after done.
- Zero length: start len=0 -> no mem_read/mem_write strobes. done pulses the cycle after acceptance. checksum=0.
- Wrap and overflow: mem[8191]=0xFFFFFF, mem[0]=2; src=8191 dst=100 len=2 -> mem[100]=0xFFFFFF, mem[101]=2, checksum=0x000001. Reads hit addresses 8191 then 0.
- Overlap: mem[10..12]=1,2,3; src=10 dst=11 len=2 -> mem[11]=1, mem[12]=1. Never both strobes high.
- Start while busy: second start with different addresses during the copy and in the DONE cycle -> ignored; only the first copy occurs. Exactly one done pulse.
- Reset mid-copy: rst_n low after the first write of a len=3 copy -> all outputs 0 asynchronously. mem[dst] written, mem[dst+1] untouched. A new start after release works normally.
